// File: rtl/program_sequencer_if.sv
// Instruction memory bus between the program sequencer (master) and a
// synchronous instruction memory (slave).
//
// Handshake: the master asserts instr_rd_en for one cycle with instr_addr
// stable; the slave returns instr_rdata on the following cycle. There is no
// back-pressure, so the memory must always accept a read.
interface program_sequencer_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 11
);
  logic                  instr_rd_en;
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic [DATA_WIDTH-1:0] instr_rdata;

  modport master (
    output instr_rd_en,
    output instr_addr,
    input  instr_rdata
  );

  modport slave (
    input  instr_rd_en,
    input  instr_addr,
    output instr_rdata
  );
endinterface

// File: rtl/program_sequencer.sv
// Fetch/execute controller for the MAC CPU datapath.
// Walks a program counter through a synchronous instruction memory, latches
// each word into the instruction register, presents opcode/operand to the
// decoder and issues a one-cycle exec_en strobe per executed instruction.
// WAIT instructions (flagged by the decoder through f_wait) park the machine
// until a fresh rising edge on go.
module program_sequencer #(
  parameter int OPCODE_WIDTH  = 3,
  parameter int OPERAND_WIDTH = 8,
  parameter int ADDR_WIDTH    = 5,
  parameter int PROG_LEN      = 32,
  parameter int LOOP          = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     go,
  program_sequencer_if.master      imem,
  output logic [OPCODE_WIDTH-1:0]  opcode,
  output logic [OPERAND_WIDTH-1:0] operand,
  input  logic                     f_wait,
  output logic                     exec_en,
  output logic                     busy,
  output logic                     waiting,
  output logic                     done,
  output logic [2:0]               dbg_state
);

  localparam int IR_WIDTH = OPCODE_WIDTH + OPERAND_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(PROG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LATCH   = 3'd2,
    S_EXEC    = 3'd3,
    S_WAIT_GO = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_nx;
  logic [IR_WIDTH-1:0]   r_ir;
  logic                  r_go_q;
  logic                  r_done;
  logic                  w_done_nx;
  logic                  w_advance;
  logic                  w_last;
  logic                  w_go_rise;

  // The last address decides whether advancing wraps, stops or increments.
  assign w_last    = (r_pc == LAST_PC);
  // Only a 0->1 transition of go counts; a level already high is ignored.
  assign w_go_rise = go & ~r_go_q;

  // State, program counter and completion pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_done  <= w_done_nx;
    end
  end

  // go history for edge detection; updates every cycle so edges seen outside
  // WAIT_GO are consumed rather than queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_go_q <= 1'b0;
    end else begin
      r_go_q <= go;
    end
  end

  // Instruction register loads in LATCH; an abort in that cycle leaves the
  // previous instruction in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir <= '0;
    end else if ((r_state == S_LATCH) && !stop) begin
      r_ir <= imem.instr_rdata;
    end
  end

  // Next-state logic: sequencing, WAIT stall, advance rule, stop override.
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_done_nx  = 1'b0;
    w_advance  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_FETCH;
          w_pc_nx    = '0;
        end
      end
      S_FETCH: begin
        w_state_nx = S_LATCH;
      end
      S_LATCH: begin
        w_state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (f_wait) begin
          w_state_nx = S_WAIT_GO;
        end else begin
          w_advance = 1'b1;
        end
      end
      S_WAIT_GO: begin
        if (w_go_rise) begin
          w_advance = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_pc_nx    = '0;
      end
    endcase

    // Shared by EXEC and WAIT_GO, so a trailing WAIT ends like any other
    // last instruction.
    if (w_advance) begin
      if (!w_last) begin
        w_pc_nx    = r_pc + ADDR_WIDTH'(1);
        w_state_nx = S_FETCH;
      end else if (LOOP != 0) begin
        w_pc_nx    = '0;
        w_state_nx = S_FETCH;
      end else begin
        w_pc_nx    = '0;
        w_state_nx = S_IDLE;
        w_done_nx  = 1'b1;
      end
    end

    // Abort wins over everything, including start in IDLE; no done pulse.
    if (stop) begin
      w_state_nx = S_IDLE;
      w_pc_nx    = '0;
      w_done_nx  = 1'b0;
    end
  end

  // Memory bus: address follows pc, read strobe only in FETCH.
  assign imem.instr_rd_en = (r_state == S_FETCH);
  assign imem.instr_addr  = r_pc;

  // Decoder-facing fields come straight from the instruction register.
  assign opcode  = r_ir[IR_WIDTH-1 -: OPCODE_WIDTH];
  assign operand = r_ir[OPERAND_WIDTH-1:0];

  // exec_en is gated by f_wait and stop combinationally so a WAIT or an
  // aborted instruction never produces a datapath write.
  assign exec_en   = (r_state == S_EXEC) & ~f_wait & ~stop;
  assign busy      = (r_state != S_IDLE);
  assign waiting   = (r_state == S_WAIT_GO);
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: three instances with different
// PROG_LEN/LOOP settings, each with its own instruction memory model and a
// decoder model that flags opcode 3'b111 as WAIT.
module tb_program_sequencer;

  localparam int OW = 3;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int IW = OW + DW;
  localparam logic [OW-1:0] WAIT_OPC = 3'b111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // ---------------- instance A: PROG_LEN=4, LOOP=0 ----------------
  logic          start_a = 0, stop_a = 0, go_a = 0;
  logic [OW-1:0] opcode_a;
  logic [DW-1:0] operand_a;
  logic          f_wait_a, exec_en_a, busy_a, waiting_a, done_a;
  logic [2:0]    state_a;
  logic [IW-1:0] mem_a [0:31];
  program_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(IW)) if_a ();

  program_sequencer #(.OPCODE_WIDTH(OW), .OPERAND_WIDTH(DW), .ADDR_WIDTH(AW),
                      .PROG_LEN(4), .LOOP(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .go(go_a),
    .imem(if_a.master), .opcode(opcode_a), .operand(operand_a),
    .f_wait(f_wait_a), .exec_en(exec_en_a), .busy(busy_a),
    .waiting(waiting_a), .done(done_a), .dbg_state(state_a)
  );
  assign f_wait_a = (opcode_a == WAIT_OPC);
  always @(posedge clk) if (if_a.instr_rd_en) if_a.instr_rdata <= mem_a[if_a.instr_addr];

  // ---------------- instance B: PROG_LEN=3, LOOP=1 ----------------
  logic          start_b = 0, stop_b = 0, go_b = 0;
  logic [OW-1:0] opcode_b;
  logic [DW-1:0] operand_b;
  logic          f_wait_b, exec_en_b, busy_b, waiting_b, done_b;
  logic [2:0]    state_b;
  logic [IW-1:0] mem_b [0:31];
  program_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(IW)) if_b ();

  program_sequencer #(.OPCODE_WIDTH(OW), .OPERAND_WIDTH(DW), .ADDR_WIDTH(AW),
                      .PROG_LEN(3), .LOOP(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .go(go_b),
    .imem(if_b.master), .opcode(opcode_b), .operand(operand_b),
    .f_wait(f_wait_b), .exec_en(exec_en_b), .busy(busy_b),
    .waiting(waiting_b), .done(done_b), .dbg_state(state_b)
  );
  assign f_wait_b = (opcode_b == WAIT_OPC);
  always @(posedge clk) if (if_b.instr_rd_en) if_b.instr_rdata <= mem_b[if_b.instr_addr];

  // ---------------- instance C: PROG_LEN=1, LOOP=1 ----------------
  logic          start_c = 0, stop_c = 0, go_c = 0;
  logic [OW-1:0] opcode_c;
  logic [DW-1:0] operand_c;
  logic          f_wait_c, exec_en_c, busy_c, waiting_c, done_c;
  logic [2:0]    state_c;
  logic [IW-1:0] mem_c [0:31];
  program_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(IW)) if_c ();

  program_sequencer #(.OPCODE_WIDTH(OW), .OPERAND_WIDTH(DW), .ADDR_WIDTH(AW),
                      .PROG_LEN(1), .LOOP(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .stop(stop_c), .go(go_c),
    .imem(if_c.master), .opcode(opcode_c), .operand(operand_c),
    .f_wait(f_wait_c), .exec_en(exec_en_c), .busy(busy_c),
    .waiting(waiting_c), .done(done_c), .dbg_state(state_c)
  );
  assign f_wait_c = (opcode_c == WAIT_OPC);
  always @(posedge clk) if (if_c.instr_rd_en) if_c.instr_rdata <= mem_c[if_c.instr_addr];

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock; afterwards we sit 1 time unit past the rising edge, which is
  // where inputs are driven and outputs sampled.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_idle_a(input string tag);
    chk({tag, "_rd_en"},   32'(if_a.instr_rd_en), 0);
    chk({tag, "_addr"},    32'(if_a.instr_addr),  0);
    chk({tag, "_exec"},    32'(exec_en_a),        0);
    chk({tag, "_busy"},    32'(busy_a),           0);
    chk({tag, "_waiting"}, 32'(waiting_a),        0);
    chk({tag, "_done"},    32'(done_a),           0);
    chk({tag, "_state"},   32'(state_a),          0);
  endtask

  // Watchdog: the whole run is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 11'h011;
      mem_b[i] = 11'h022;
      mem_c[i] = 11'h033;
    end

    // ---------- reset state ----------
    tick();
    check_idle_a("rst_hold");
    chk("rst_opcode",  32'(opcode_a),  0);
    chk("rst_operand", 32'(operand_a), 0);
    tick();
    rst = 1'b0;
    tick();
    check_idle_a("rst_rel");

    // ---------- linear run, PROG_LEN=4 LOOP=0 ----------
    mem_a[0] = 11'b101_10100011;
    mem_a[1] = 11'b000_00010010;
    mem_a[2] = 11'b010_00110100;
    mem_a[3] = 11'b011_11000101;
    cyc = 0;
    start_a = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      start_a = 1'b0;
      chk("lin_rd_en", 32'(if_a.instr_rd_en), 32'(cyc == 1 || cyc == 4 || cyc == 7 || cyc == 10));
      if (cyc == 1 || cyc == 4 || cyc == 7 || cyc == 10)
        chk("lin_addr", 32'(if_a.instr_addr), 32'((cyc - 1) / 3));
      chk("lin_exec", 32'(exec_en_a), 32'(cyc == 3 || cyc == 6 || cyc == 9 || cyc == 12));
      chk("lin_done", 32'(done_a), 32'(cyc == 13));
      chk("lin_busy", 32'(busy_a), 32'(cyc >= 1 && cyc <= 12));
      if (cyc == 3 || cyc == 5) begin
        chk("op_opcode",  32'(opcode_a),  32'h5);
        chk("op_operand", 32'(operand_a), 32'hA3);
      end
      if (cyc == 6) begin
        chk("op2_opcode",  32'(opcode_a),  32'h0);
        chk("op2_operand", 32'(operand_a), 32'h12);
      end
    end
    chk("lin_end_state", 32'(state_a), 0);

    // ---------- WAIT stall with go held high on entry ----------
    mem_a[1] = 11'b111_00000000;
    go_a = 1'b1;
    tick();
    cyc = 0;
    start_a = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      start_a = 1'b0;
    end
    // cycle 6 is EXEC of the WAIT word
    chk("wait_exec_gated", 32'(exec_en_a), 0);
    chk("wait_state_exec", 32'(state_a),   3);
    for (int k = 7; k <= 26; k++) begin
      tick();
      chk("wait_waiting", 32'(waiting_a),       1);
      chk("wait_pc",      32'(if_a.instr_addr), 1);
      chk("wait_exec",    32'(exec_en_a),       0);
    end
    tick();               // cycle 27
    go_a = 1'b0;
    tick();               // cycle 28
    chk("wait_still", 32'(waiting_a), 1);
    go_a = 1'b1;
    tick();               // cycle 29: FETCH of address 2
    chk("resume_rd_en",   32'(if_a.instr_rd_en), 1);
    chk("resume_addr",    32'(if_a.instr_addr),  2);
    chk("resume_waiting", 32'(waiting_a),        0);
    tick();               // cycle 30: LATCH
    tick();               // cycle 31: EXEC of address 2
    stop_a = 1'b1;
    #1;
    chk("stop_exec", 32'(exec_en_a), 0);
    chk("stop_busy", 32'(busy_a),    1);
    tick();               // cycle 32
    stop_a = 1'b0;
    go_a = 1'b0;
    check_idle_a("stop_idle");
    chk("stop_ir_kept", 32'(opcode_a), 32'h2);

    // ---------- start and stop together in IDLE ----------
    start_a = 1'b1;
    stop_a  = 1'b1;
    tick();
    tick();
    check_idle_a("startstop");
    start_a = 1'b0;
    stop_a  = 1'b0;
    tick();

    // ---------- asynchronous reset mid-EXEC ----------
    mem_a[1] = 11'b001_01010101;
    cyc = 0;
    start_a = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      start_a = 1'b0;
    end
    chk("prerst_exec", 32'(exec_en_a), 1);
    #2;
    rst = 1'b1;
    #1;
    check_idle_a("async_rst");
    chk("async_rst_opcode",  32'(opcode_a),  0);
    chk("async_rst_operand", 32'(operand_a), 0);
    #1;
    rst = 1'b0;
    tick();
    check_idle_a("after_rst");

    // ---------- wrap, PROG_LEN=3 LOOP=1 ----------
    exp_q.push_back(5'd0);
    exp_q.push_back(5'd1);
    exp_q.push_back(5'd2);
    exp_q.push_back(5'd0);
    exp_q.push_back(5'd1);
    cyc = 0;
    start_b = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      start_b = 1'b0;
      chk("wrap_fetch_slot", 32'(if_b.instr_rd_en), 32'(cyc % 3 == 1));
      if (if_b.instr_rd_en) begin
        if (exp_q.size() == 0) chk("wrap_extra_fetch", 32'(if_b.instr_addr), 32'hFFFF);
        else chk("wrap_addr", 32'(if_b.instr_addr), 32'(exp_q.pop_front()));
      end
      chk("wrap_done", 32'(done_b), 0);
    end
    chk("wrap_left", 32'(exp_q.size()), 0);
    stop_b = 1'b1;
    tick();
    stop_b = 1'b0;
    chk("wrap_stopped", 32'(busy_b), 0);

    // ---------- PROG_LEN=1 LOOP=1 ----------
    cyc = 0;
    start_c = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      start_c = 1'b0;
      chk("len1_exec", 32'(exec_en_c), 32'(cyc % 3 == 0));
      chk("len1_addr", 32'(if_c.instr_addr), 0);
      chk("len1_done", 32'(done_c), 0);
    end
    stop_c = 1'b1;
    tick();
    stop_c = 1'b0;
    chk("len1_stopped", 32'(busy_c), 0);

    // ---------- report ----------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Fetch/execute controller for the MAC CPU datapath.
- Steps a program counter through a synchronous instruction memory and latches each instruction word.
- Presents the opcode and operand to instruction_decoder and issues a one-cycle execute strobe that qualifies every datapath register write.
- Uses the decoder's f_wait output to stall on WAIT instructions until an external go event.

Parameters:
OPCODE_WIDTH, 3, opcode field width; matches instruction_decoder.
OPERAND_WIDTH, 8, operand field width.
ADDR_WIDTH, 5, instruction memory address width.
PROG_LEN, 32, number of instructions in the program; 1 <= PROG_LEN <= 2**ADDR_WIDTH.
LOOP, 1, 1 = wrap to address 0 after the last instruction; 0 = stop after the last instruction.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  level sampled in IDLE; begins execution at address 0.
stop  in  1  abort; returns to IDLE from any state.
go  in  1  resume request for WAIT; only a rising edge counts.
instr_rd_en  out  1  instruction memory read enable.
instr_addr  out  ADDR_WIDTH  instruction memory address (equals pc).
instr_rdata  in  OPCODE_WIDTH+OPERAND_WIDTH  read data, valid 1 cycle after instr_rd_en; opcode in MSBs.
opcode  out  OPCODE_WIDTH  latched opcode field, to instruction_decoder.
operand  out  OPERAND_WIDTH  latched operand field, to datapath.
f_wait  in  1  from instruction_decoder; combinational function of opcode.
exec_en  out  1  one-cycle strobe; the datapath gates all decoder-driven writes with it.
busy  out  1  high in every state except IDLE.
waiting  out  1  high in WAIT_GO.
done  out  1  one-cycle pulse on completion when LOOP=0.

Behaviour:
- Reset values: state=IDLE, pc=0, IR=0, go_q=0; outputs instr_rd_en=0, instr_addr=0, opcode=0, operand=0, exec_en=0, busy=0, waiting=0, done=0.
- States and transitions:
  - IDLE: if start=1 and stop=0, set pc=0 and go to FETCH; otherwise stay.
  - FETCH: drive instr_rd_en=1 and instr_addr=pc; go to LATCH.
  - LATCH: load IR from instr_rdata; go to EXEC.
  - EXEC: opcode/operand are now stable from IR.
    - If f_wait=0: exec_en=1 for this cycle only, then advance.
    - If f_wait=1: exec_en=0; go to WAIT_GO.
  - WAIT_GO: exec_en=0 and waiting=1. On a go rising edge, advance.
- go edge detect: go_q is a register of go. A rising edge is go=1 while go_q=0.
  - go_q updates every cycle, so go already high on entry to WAIT_GO needs a fresh 0->1 transition.
  - Edges outside WAIT_GO are discarded, not queued.
- Advance rule:
  - If pc != PROG_LEN-1: pc=pc+1, go to FETCH.
  - If pc == PROG_LEN-1 and LOOP=1: pc=0, go to FETCH.
  - If pc == PROG_LEN-1 and LOOP=0: pc=0, go to IDLE, done=1 for one cycle.
- pc is ADDR_WIDTH bits and never exceeds PROG_LEN-1.
- Latency:
  - A non-WAIT instruction takes exactly 3 cycles (FETCH, LATCH, EXEC), with exec_en high in the 3rd.
  - With start asserted at IDLE edge t, FETCH runs in cycle t+1 and the first exec_en is in cycle t+3.
- stop:
  - Takes priority over every transition, including start in IDLE.
  - Next state is IDLE with pc=0.
  - exec_en is forced 0 combinationally in the cycle stop=1, so no datapath write occurs.
  - done is not pulsed.
  - IR keeps its value.
- A WAIT as the last instruction follows the advance rule when go arrives.
- PROG_LEN=1 with LOOP=1 re-executes address 0 every 3 cycles.
- Asynchronous reset mid-instruction clears everything immediately; no partial exec_en.
- exec_en, waiting, busy and done are registered-state decodes. exec_en additionally includes the combinational f_wait and stop gating.

Test Plan:
- Reset: assert rst mid-EXEC -> all outputs 0 within the same cycle; state IDLE after release.
- Linear run: PROG_LEN=4, LOOP=0, memory of four non-WAIT words, start pulse at cycle 0 -> instr_addr 0,1,2,3 on FETCH cycles 1,4,7,10; exec_en in cycles 3,6,9,12; done=1 in cycle 13; busy=0 afterwards.
- Wrap: PROG_LEN=3, LOOP=1 -> addresses 0,1,2,0,1 on successive FETCH cycles; done never asserted.
- WAIT stall: word 1 is WAIT with go held high on entry -> waiting=1 and pc=1 persist for 20 cycles with no exec_en.
  - Drop go then raise it -> FETCH of address 2 follows on the cycle after the rising edge.
- Stop priority: stop=1 in the EXEC cycle of address 2 -> exec_en=0 that cycle, IDLE next, pc=0.
  - start and stop both high in IDLE -> remains IDLE.
- Operand/opcode: instr_rdata=0b101_10100011 at address 0 -> opcode=3'b101 and operand=8'hA3 from the LATCH edge onward; values hold until the next LATCH.
